// File: rtl/inst_rom_resp.sv
// Instruction-memory responder: accepts fetch requests, returns the stored word after
// WAIT_CYCLES wait states, and flags misaligned or out-of-range fetches. Includes a loader write port.
module inst_rom_resp #(
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] NOP_INS     = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if2rom_req_i,
    input  logic [31:0] if2rom_addr_i,
    output logic [31:0] rom2if_ins_o,
    output logic        rom2if_valid_o,
    output logic        rom2if_err_o,
    output logic        rom2if_busy_o,
    input  logic        ld_we_i,
    input  logic [31:0] ld_addr_i,
    input  logic [31:0] ld_data_i
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [32:0] LIMIT    = 33'(DEPTH) * 33'd4;
    localparam logic [3:0]  CNT_INIT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    // Returns {fault, word index} for a byte address.
    function automatic logic [AW:0] decode(input logic [31:0] a);
        logic [31:0] off;
        logic        flt;
        off = a - BASE_ADDR;
        flt = (a[1:0] != 2'b00) || ({1'b0, off} >= LIMIT);
        return {flt, off[AW+1:2]};
    endfunction

    logic [31:0]   mem_q [DEPTH];
    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          fault_q, fault_d;
    logic [31:0]   ins_q, ins_d;
    logic          err_q, err_d;

    logic [AW:0]   req_dec, ld_dec;
    logic [AW-1:0] rd_idx;
    logic          rd_fault;
    logic          load_resp;

    assign req_dec = decode(if2rom_addr_i);
    assign ld_dec  = decode(ld_addr_i);

    // Memory is never reset; a same-edge read sees the pre-write contents.
    always_ff @(posedge clk) begin
        if (ld_we_i && !ld_dec[AW])
            mem_q[ld_dec[AW-1:0]] <= ld_data_i;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        fault_d   = fault_q;
        load_resp = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (if2rom_req_i) begin
                    idx_d   = req_dec[AW-1:0];
                    fault_d = req_dec[AW];
                    if (WAIT_CYCLES == 0) begin
                        state_d   = RESP;
                        load_resp = 1'b1;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d   = RESP;
                    load_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // With zero wait states the response is read straight from the incoming address.
    always_comb begin
        rd_idx   = (state_q == WAIT) ? idx_q   : req_dec[AW-1:0];
        rd_fault = (state_q == WAIT) ? fault_q : req_dec[AW];
        ins_d    = ins_q;
        err_d    = err_q;
        if (load_resp) begin
            ins_d = rd_fault ? NOP_INS : mem_q[rd_idx];
            err_d = rd_fault;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            fault_q <= 1'b0;
            ins_q   <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            fault_q <= fault_d;
            ins_q   <= ins_d;
            err_q   <= err_d;
        end
    end

    assign rom2if_ins_o   = ins_q;
    assign rom2if_err_o   = err_q;
    assign rom2if_valid_o = (state_q == RESP);
    assign rom2if_busy_o  = (state_q == WAIT);
endmodule
